multi_sample_fetcher: RTL and testbench

Parametrised multi-channel DDR3 sample fetcher for the APU. Each channel is given a block base address and streams a fixed number of 64-bit chunks from memory into a private prefetch FIFO. Channels share one memory read port through a round-robin arbiter with one read in flight at a time. A second base address can be queued per channel, so a channel moves from one block to the next without a gap.

---
 rtl/multi_sample_fetcher.sv | 222 ++++++++++++++++++++++
 tb/tb_multi_sample_fetcher.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_sample_fetcher.sv
// Multi-channel block sample fetcher. Each channel streams BLOCK_CHUNKS
// 64-bit words from a base address into a private first-word-fall-through
// FIFO. All channels share one read port, arbitrated round-robin, with a
// single read outstanding at a time. A second base can be queued per channel
// so consecutive blocks are fetched without a gap.
module multi_sample_fetcher #(
  parameter int CHANNELS     = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int BLOCK_CHUNKS = 64
) (
  input  logic                   clock,
  input  logic                   reset_l,
  input  logic [63:0]            mem_data,
  input  logic                   mem_ack,
  output logic [28:0]            mem_addr,
  output logic                   mem_read_en,
  output logic [CHANNELS*64-1:0] chunk,
  output logic [CHANNELS-1:0]    chunk_valid,
  input  logic [CHANNELS-1:0]    chunk_ack,
  input  logic [CHANNELS*29-1:0] base,
  input  logic [CHANNELS-1:0]    base_valid,
  output logic [CHANNELS-1:0]    base_ack,
  output logic [CHANNELS-1:0]    block_done
);

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int IDX_W = $clog2(BLOCK_CHUNKS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_CHUNKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WAIT
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CH_W-1:0] r_rr_ptr;
  logic [CH_W-1:0] r_gnt;
  logic            r_gnt_last;
  logic [28:0]     r_mem_addr;
  logic            r_mem_read_en;
  logic [CHANNELS-1:0] r_block_done;

  logic [28:0]      r_pend_base [CHANNELS];
  logic [CHANNELS-1:0] r_pend_valid;
  logic [28:0]      r_act_base [CHANNELS];
  logic [IDX_W-1:0] r_act_idx [CHANNELS];
  logic [CHANNELS-1:0] r_active;
  logic [CHANNELS-1:0] r_inflight;
  logic [CNT_W-1:0] r_count [CHANNELS];
  logic [PTR_W-1:0] r_rd_ptr [CHANNELS];
  logic [PTR_W-1:0] r_wr_ptr [CHANNELS];
  logic [63:0]      r_fifo [CHANNELS][FIFO_DEPTH];

  logic [CHANNELS-1:0] w_eligible;
  logic [CHANNELS-1:0] w_base_ack;
  logic [CHANNELS-1:0] w_gnt_sel;
  logic [CHANNELS-1:0] w_push;
  logic [CHANNELS-1:0] w_pop;
  logic [CHANNELS-1:0] w_chunk_valid;
  logic                w_found;
  logic [CH_W-1:0]     w_gnt;
  logic [CH_W-1:0]     w_rr_next;
  logic                w_grant;
  logic                w_ack_take;

  assign w_base_ack  = base_valid & ~r_pend_valid;
  assign w_grant     = (r_state == S_IDLE) && w_found;
  // An ack only completes a read that is actually outstanding.
  assign w_ack_take  = mem_ack && (r_state != S_IDLE);
  assign w_rr_next   = (int'(w_gnt) == CHANNELS - 1) ? '0 : w_gnt + CH_W'(1);

  assign base_ack    = w_base_ack;
  assign mem_addr    = r_mem_addr;
  assign mem_read_en = r_mem_read_en;
  assign block_done  = r_block_done;
  assign chunk_valid = w_chunk_valid;

  // Per-channel handshake decode: eligibility, grant select, FIFO push/pop.
  always_comb begin
    w_eligible = '0;
    w_gnt_sel  = '0;
    w_push     = '0;
    w_pop      = '0;
    w_chunk_valid = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      // Counting the in-flight read reserves its FIFO slot, so a push never overflows.
      w_eligible[c] = r_active[c] &&
                      ((int'(r_count[c]) + int'(r_inflight[c])) < FIFO_DEPTH);
      w_gnt_sel[c]  = w_grant && (int'(w_gnt) == c);
      w_push[c]     = w_ack_take && (int'(r_gnt) == c);
      w_chunk_valid[c] = (r_count[c] != '0);
      w_pop[c]      = chunk_ack[c] && w_chunk_valid[c];
    end
  end

  // Round-robin search for the first eligible channel starting at rr_ptr.
  always_comb begin : arb
    int v_idx;
    v_idx   = 0;
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      v_idx = (int'(r_rr_ptr) + k) % CHANNELS;
      if (!w_found && w_eligible[v_idx]) begin
        w_found = 1'b1;
        w_gnt   = CH_W'(v_idx);
      end
    end
  end

  // Read FSM next-state: one request cycle, then wait for the ack.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_grant) w_state_next = S_READ;
      S_READ: w_state_next = mem_ack ? S_IDLE : S_WAIT;
      S_WAIT: if (mem_ack) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Grant bookkeeping, registered memory request and block_done pulse.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      r_rr_ptr      <= '0;
      r_gnt         <= '0;
      r_gnt_last    <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_read_en <= 1'b0;
      r_block_done  <= '0;
    end else begin
      r_mem_read_en <= w_grant;
      r_block_done  <= '0;
      if (w_grant) begin
        r_gnt      <= w_gnt;
        r_gnt_last <= (r_act_idx[w_gnt] == LAST_IDX);
        r_mem_addr <= r_act_base[w_gnt] + {{(29 - IDX_W){1'b0}}, r_act_idx[w_gnt]};
        r_rr_ptr   <= w_rr_next;
      end
      if (w_ack_take && r_gnt_last) r_block_done[r_gnt] <= 1'b1;
    end
  end

  // Per-channel pending slot, active block, in-flight flag and FIFO occupancy.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      r_pend_valid <= '0;
      r_active     <= '0;
      r_inflight   <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_pend_base[c] <= '0;
        r_act_base[c]  <= '0;
        r_act_idx[c]   <= '0;
        r_count[c]     <= '0;
        r_rd_ptr[c]    <= '0;
        r_wr_ptr[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        // The slot only loads while empty and only promotes while full, so these never collide.
        if (w_base_ack[c]) begin
          r_pend_base[c]  <= base[c*29 +: 29];
          r_pend_valid[c] <= 1'b1;
        end
        if (!r_active[c] && r_pend_valid[c]) begin
          r_active[c]     <= 1'b1;
          r_act_base[c]   <= r_pend_base[c];
          r_act_idx[c]    <= '0;
          r_pend_valid[c] <= 1'b0;
        end else if (w_gnt_sel[c]) begin
          if (r_act_idx[c] == LAST_IDX) begin
            // Chain straight into the queued block so the next grant has no gap.
            if (r_pend_valid[c]) begin
              r_act_base[c]   <= r_pend_base[c];
              r_act_idx[c]    <= '0;
              r_pend_valid[c] <= 1'b0;
            end else begin
              r_active[c] <= 1'b0;
            end
          end else begin
            r_act_idx[c] <= r_act_idx[c] + IDX_W'(1);
          end
        end

        if (w_gnt_sel[c])   r_inflight[c] <= 1'b1;
        else if (w_push[c]) r_inflight[c] <= 1'b0;

        if (w_push[c] && !w_pop[c])      r_count[c] <= r_count[c] + CNT_W'(1);
        else if (!w_push[c] && w_pop[c]) r_count[c] <= r_count[c] - CNT_W'(1);
        if (w_push[c]) r_wr_ptr[c] <= r_wr_ptr[c] + PTR_W'(1);
        if (w_pop[c])  r_rd_ptr[c] <= r_rd_ptr[c] + PTR_W'(1);
      end
    end
  end

  // FIFO storage; contents are only observed through the occupancy count.
  always_ff @(posedge clock) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_push[c]) r_fifo[c][r_wr_ptr[c]] <= mem_data;
    end
  end

  // Fall-through head of each FIFO, forced to zero while empty.
  always_comb begin
    chunk = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_chunk_valid[c]) chunk[c*64 +: 64] = r_fifo[c][r_rd_ptr[c]];
    end
  end

endmodule

// File: tb/tb_multi_sample_fetcher.sv
// Bench for multi_sample_fetcher: 3 channels, 4-deep FIFOs, 4-chunk blocks.
module tb_multi_sample_fetcher;

  localparam int CH = 3;

  logic               clock;
  logic               reset_l;
  logic [63:0]        mem_data;
  logic               mem_ack;
  logic [28:0]        mem_addr;
  logic               mem_read_en;
  logic [CH*64-1:0]   chunk;
  logic [CH-1:0]      chunk_valid;
  logic [CH-1:0]      chunk_ack;
  logic [CH*29-1:0]   base;
  logic [CH-1:0]      base_valid;
  logic [CH-1:0]      base_ack;
  logic [CH-1:0]      block_done;

  multi_sample_fetcher #(.CHANNELS(CH), .FIFO_DEPTH(4), .BLOCK_CHUNKS(4)) dut (
    .clock(clock), .reset_l(reset_l), .mem_data(mem_data), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_read_en(mem_read_en), .chunk(chunk),
    .chunk_valid(chunk_valid), .chunk_ack(chunk_ack), .base(base),
    .base_valid(base_valid), .base_ack(base_ack), .block_done(block_done)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // memory responder controls
  bit  resp_on = 1;
  bit  resp_rand = 0;
  int  resp_lat = 1;
  bit  man_ack = 0;
  logic [63:0] man_data = '0;

  // observation logs
  logic [28:0] rd_addr[$];
  int          rd_cyc[$];
  logic [28:0] ack_addr[$];
  int          ack_cyc[$];
  logic [63:0] pop_d[$];
  int          pop_ch[$];
  int          done_ch[$];
  int          done_cyc[$];

  function automatic logic [63:0] fdata(input logic [28:0] a);
    return {3'b101, a, 3'b010, a ^ 29'h0ABCDEF1};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Memory model: answers each read after a chosen latency with fdata(addr).
  initial begin : responder
    bit busy;
    int left;
    busy = 0;
    left = 0;
    mem_ack = 0;
    mem_data = '0;
    forever begin
      @(posedge clock);
      #2;
      if (!reset_l) busy = 0;
      if (!resp_on) begin
        mem_ack  = man_ack;
        mem_data = man_data;
      end else begin
        mem_ack = 0;
        if (reset_l && mem_read_en) begin
          left = resp_rand ? int'($urandom_range(0, 3)) : resp_lat;
          busy = 1;
        end else if (reset_l && busy) begin
          left--;
        end
        if (busy && left == 0) begin
          mem_ack  = 1;
          mem_data = fdata(mem_addr);
          busy     = 0;
        end
      end
    end
  end

  // Monitor: logs reads, acks, pops and block_done pulses mid-cycle.
  initial forever begin
    @(negedge clock);
    if (mem_read_en) begin rd_addr.push_back(mem_addr); rd_cyc.push_back(cyc); end
    if (mem_ack) begin ack_addr.push_back(mem_addr); ack_cyc.push_back(cyc); end
    for (int c = 0; c < CH; c++) begin
      if (chunk_valid[c] && chunk_ack[c]) begin
        pop_d.push_back(chunk[c*64 +: 64]);
        pop_ch.push_back(c);
      end
      if (block_done[c]) begin done_ch.push_back(c); done_cyc.push_back(cyc); end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic clear_logs();
    rd_addr.delete(); rd_cyc.delete(); ack_addr.delete(); ack_cyc.delete();
    pop_d.delete(); pop_ch.delete(); done_ch.delete(); done_cyc.delete();
  endtask

  task automatic do_reset();
    reset_l = 0;
    base_valid = '0;
    chunk_ack = '0;
    man_ack = 0;
    tick(2);
    reset_l = 1;
    tick(1);
    clear_logs();
  endtask

  task automatic offer(input int ch, input logic [28:0] a, output int acc_cyc);
    bit got;
    got = 0;
    acc_cyc = -1;
    base[ch*29 +: 29] = a;
    base_valid[ch] = 1'b1;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clock);
      if (base_ack[ch]) begin got = 1; acc_cyc = cyc; end
      @(posedge clock);
      #1;
    end
    base_valid[ch] = 1'b0;
    chk("offer_accepted", 64'(got), 64'd1);
  endtask

  logic [28:0] exp_q[$];
  logic [28:0] ebase[CH][3];
  int a1, a2, a3, rem[CH], ptr, cnt, bidx[CH];
  bit found;
  logic [CH-1:0] acc;

  initial begin
    reset_l = 0;
    base = '0;
    base_valid = '0;
    chunk_ack = '0;

    // ---- reset values, base_ack follows base_valid while idle ----
    tick(2);
    chk("rst_read_en", 64'(mem_read_en), 0);
    chk("rst_addr", 64'(mem_addr), 0);
    chk("rst_chunk_valid", 64'(chunk_valid), 0);
    chk("rst_chunk", 64'(chunk[63:0]) | 64'(chunk[191:128]), 0);
    chk("rst_block_done", 64'(block_done), 0);
    base_valid = 3'b101;
    #1;
    chk("rst_base_ack", 64'(base_ack), 64'b101);
    base_valid = '0;
    #1;
    reset_l = 1;
    tick(3);
    chk("post_rst_read_en", 64'(mem_read_en), 0);
    chk("post_rst_base_ack", 64'(base_ack), 0);

    // ---- single block, 1-cycle latency, consumer always ready ----
    do_reset();
    resp_on = 1; resp_rand = 0; resp_lat = 1;
    chunk_ack = 3'b001;
    offer(0, 29'h100, a1);
    tick(30);
    chk("single_nreads", rd_addr.size(), 4);
    if (rd_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("single_addr", 64'(rd_addr[i]), 64'(29'h100 + i));
      chk("single_first_latency", rd_cyc[0], a1 + 3);
      for (int i = 1; i < 4; i++) chk("single_spacing", rd_cyc[i] - rd_cyc[i-1], 3);
    end
    chk("single_npops", pop_d.size(), 4);
    if (pop_d.size() == 4)
      for (int i = 0; i < 4; i++) chk("single_data", pop_d[i], fdata(29'h100 + i));
    chk("single_ndone", done_ch.size(), 1);
    if (done_ch.size() == 1 && ack_cyc.size() == 4) begin
      chk("single_done_ch", done_ch[0], 0);
      chk("single_done_cyc", done_cyc[0], ack_cyc[3] + 1);
    end

    // ---- back-pressure: consumer stalled ----
    do_reset();
    chunk_ack = '0;
    offer(1, 29'h300, a1);
    offer(1, 29'h304, a2);
    tick(30);
    chk("bp_nreads", rd_addr.size(), 4);
    if (rd_addr.size() >= 4)
      for (int i = 0; i < 4; i++) chk("bp_addr", 64'(rd_addr[i]), 64'(29'h300 + i));
    chk("bp_valid", 64'(chunk_valid), 64'b010);
    chk("bp_head", chunk[127:64], fdata(29'h300));
    chunk_ack = 3'b010;
    tick(1);
    chunk_ack = '0;
    tick(20);
    chk("bp_nreads_after_pop", rd_addr.size(), 5);
    if (rd_addr.size() >= 5) chk("bp_addr_after_pop", 64'(rd_addr[4]), 64'(29'h304));
    chk("bp_npops", pop_d.size(), 1);
    if (pop_d.size() >= 1) chk("bp_pop_data", pop_d[0], fdata(29'h300));
    chk("bp_new_head", chunk[127:64], fdata(29'h301));

    // ---- queued bases ----
    do_reset();
    chunk_ack = 3'b111;
    offer(0, 29'h100, a1);
    offer(0, 29'h200, a2);
    offer(0, 29'h400, a3);
    tick(50);
    chk("q_nreads", rd_addr.size(), 12);
    if (rd_addr.size() == 12) begin
      for (int i = 0; i < 12; i++)
        chk("q_addr", 64'(rd_addr[i]),
            64'((i < 4) ? 29'h100 + i : (i < 8) ? 29'h200 + i - 4 : 29'h400 + i - 8));
      chk("q_second_accept", a2, a1 + 2);
      chk("q_third_held", a3, rd_cyc[3]);
      chk("q_no_gap", rd_cyc[4] - rd_cyc[3], rd_cyc[1] - rd_cyc[0]);
    end
    chk("q_ndone", done_ch.size(), 3);

    // ---- round-robin, channel 1 never drained ----
    do_reset();
    chunk_ack = 3'b101;
    base = {29'h3000, 29'h2000, 29'h1000};
    base_valid = 3'b111;
    @(negedge clock);
    chk("rr_accept1", 64'(base_ack), 64'b111);
    tick(1);
    base = {29'h3100, 29'h2100, 29'h1100};
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clock);
      if (base_ack == 3'b111) found = 1;
      tick(1);
    end
    base_valid = '0;
    chk("rr_accept2", 64'(found), 1);
    tick(120);
    exp_q.delete();
    rem = '{8, 4, 8};
    ptr = 0;
    for (int s = 0; s < 20; s++) begin
      found = 0;
      for (int k = 0; k < CH; k++) begin
        int c;
        c = (ptr + k) % CH;
        if (!found && rem[c] > 0) begin
          cnt = ((c == 1) ? 4 : 8) - rem[c];
          exp_q.push_back(((cnt < 4) ? 29'h1000 : 29'h1100) + 29'(c * 29'h1000) + 29'(cnt % 4));
          rem[c]--;
          ptr = (c + 1) % CH;
          found = 1;
        end
      end
    end
    chk("rr_nreads", rd_addr.size(), 20);
    if (rd_addr.size() == 20)
      for (int i = 0; i < 20; i++) chk("rr_addr", 64'(rd_addr[i]), 64'(exp_q[i]));

    // ---- address wrap with zero-wait acks ----
    do_reset();
    resp_lat = 0;
    chunk_ack = 3'b111;
    offer(2, 29'h1FFFFFFE, a1);
    tick(30);
    chk("wrap_nreads", rd_addr.size(), 4);
    if (rd_addr.size() == 4 && ack_cyc.size() == 4) begin
      exp_q = '{29'h1FFFFFFE, 29'h1FFFFFFF, 29'h0, 29'h1};
      for (int i = 0; i < 4; i++) begin
        chk("wrap_addr", 64'(rd_addr[i]), 64'(exp_q[i]));
        chk("wrap_zero_wait", ack_cyc[i], rd_cyc[i]);
        if (i > 0) chk("wrap_spacing", rd_cyc[i] - rd_cyc[i-1], 2);
      end
    end
    chk("wrap_npops", pop_d.size(), 4);
    if (pop_d.size() == 4)
      for (int i = 0; i < 4; i++) chk("wrap_data", pop_d[i], fdata(exp_q[i]));
    chk("wrap_ndone", done_ch.size(), 1);
    if (done_ch.size() == 1) chk("wrap_done_ch", done_ch[0], 2);

    // ---- reset during WAIT, late ack ignored ----
    do_reset();
    resp_on = 0;
    offer(0, 29'h500, a1);
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clock);
      if (mem_read_en) found = 1;
      tick(1);
    end
    chk("wait_read_seen", 64'(found), 1);
    tick(1);
    chk("wait_addr_before_rst", 64'(mem_addr), 64'(29'h500));
    reset_l = 0;
    #1;
    chk("wait_rst_addr", 64'(mem_addr), 0);
    chk("wait_rst_read_en", 64'(mem_read_en), 0);
    chk("wait_rst_valid", 64'(chunk_valid), 0);
    chk("wait_rst_done", 64'(block_done), 0);
    tick(1);
    reset_l = 1;
    clear_logs();
    tick(1);
    man_ack = 1;
    man_data = {$urandom, $urandom};
    tick(1);
    man_ack = 0;
    tick(10);
    chk("late_ack_valid", 64'(chunk_valid), 0);
    chk("late_ack_reads", rd_addr.size(), 0);
    chk("late_ack_done", done_ch.size(), 0);
    resp_on = 1;

    // ---- randomized traffic against the block/FIFO reference ----
    do_reset();
    resp_rand = 1;
    for (int c = 0; c < CH; c++) begin
      bidx[c] = 0;
      for (int b = 0; b < 3; b++) ebase[c][b] = 29'((c << 16) | (int'($urandom_range(0, 255)) << 2));
    end
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < CH; c++) begin
        base_valid[c] = (bidx[c] < 3);
        base[c*29 +: 29] = ebase[c][(bidx[c] < 3) ? bidx[c] : 0];
      end
      chunk_ack = 3'($urandom);
      @(negedge clock);
      acc = base_valid & base_ack;
      tick(1);
      for (int c = 0; c < CH; c++) if (acc[c]) bidx[c]++;
    end
    base_valid = '0;
    chunk_ack = 3'b111;
    tick(60);
    chk("rand_nreads", rd_addr.size(), 36);
    chk("rand_nacks", ack_cyc.size(), rd_cyc.size());
    for (int c = 0; c < CH; c++) begin
      cnt = 0;
      for (int j = 0; j < pop_d.size(); j++) begin
        if (pop_ch[j] == c) begin
          if (cnt < 12) chk("rand_data", pop_d[j], fdata(ebase[c][cnt / 4] + 29'(cnt % 4)));
          cnt++;
        end
      end
      chk("rand_npops", cnt, 12);
    end
    cnt = 0;
    for (int j = 0; j < ack_addr.size(); j++) begin
      if (ack_addr[j][1:0] == 2'b11) begin
        found = 0;
        for (int d = 0; d < done_ch.size(); d++)
          if (done_ch[d] == int'(ack_addr[j][17:16]) && done_cyc[d] == ack_cyc[j] + 1) found = 1;
        chk("rand_done_match", 64'(found), 1);
        cnt++;
      end
    end
    chk("rand_ndone", done_ch.size(), cnt);
    if (ack_cyc.size() == rd_cyc.size())
      for (int i = 1; i < rd_cyc.size(); i++)
        chk("rand_spacing", 64'(rd_cyc[i] >= ack_cyc[i-1] + 2), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
